// File: rtl/adc_edge_conditioner_if.sv
// rtl/adc_edge_conditioner_if.sv - ADC sample input and conditioned square-wave/metric outputs
interface adc_edge_conditioner_if #(
   parameter int DATA_W = 10
);
   logic [DATA_W-1:0] adc_data;
   logic              sq_out;
   logic              rise_pulse;
   logic              fall_pulse;
   logic [DATA_W-1:0] thresh;
   logic [DATA_W-1:0] amp;
   logic              sig_present;
   logic              win_done;

   modport master (
      output adc_data,
      input  sq_out, rise_pulse, fall_pulse, thresh, amp, sig_present, win_done
   );

   modport slave (
      input  adc_data,
      output sq_out, rise_pulse, fall_pulse, thresh, amp, sig_present, win_done
   );
endinterface

// File: rtl/adc_edge_conditioner.sv
// rtl/adc_edge_conditioner.sv - adaptive-threshold ADC slicer with hysteresis and glitch qualifier
module adc_edge_conditioner #(
   parameter int DATA_W     = 10,
   parameter int HYST       = 16,
   parameter int GLITCH     = 2,
   parameter int WIN_CYCLES = 1000000
) (
   input logic                   clk_10m,
   input logic                   rst,
   adc_edge_conditioner_if.slave bus
);
   localparam int CNT_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
   localparam int Q_W   = $clog2(GLITCH + 1);
   localparam logic [DATA_W-1:0] MID   = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ALL_1 = {DATA_W{1'b1}};

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_RISE_CHK = 2'd1,
      S_HIGH     = 2'd2,
      S_FALL_CHK = 2'd3
   } state_t;

   logic [DATA_W-1:0] adc_q;
   logic [CNT_W-1:0]  win_cnt;
   logic [DATA_W-1:0] run_max, run_min;
   logic [DATA_W-1:0] cur_thresh, amp_val;
   logic              present, win_pulse;
   logic              win_last;
   logic [DATA_W-1:0] mx, mn, span;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   hi_sum;
   logic [DATA_W-1:0] hi_th, lo_th;
   logic              above, below;

   state_t            state, state_nx;
   logic [Q_W-1:0]    q_cnt, q_cnt_nx, q_inc;
   logic              rise_q, fall_q, rise_nx, fall_nx;

   assign win_last = (win_cnt == CNT_W'(WIN_CYCLES - 1));

   // Window extremes include the sample arriving on the closing cycle.
   always_comb begin
      mx   = (adc_q > run_max) ? adc_q : run_max;
      mn   = (adc_q < run_min) ? adc_q : run_min;
      sum  = {1'b0, mx} + {1'b0, mn};
      span = mx - mn;
   end

   always_ff @(posedge clk_10m) begin
      adc_q <= bus.adc_data;
      if (rst) begin
         win_cnt    <= '0;
         run_max    <= '0;
         run_min    <= ALL_1;
         cur_thresh <= MID;
         amp_val    <= '0;
         present    <= 1'b0;
         win_pulse  <= 1'b0;
      end else begin
         win_pulse <= win_last;
         if (win_last) begin
            win_cnt    <= '0;
            run_max    <= '0;
            run_min    <= ALL_1;
            cur_thresh <= sum[DATA_W:1];
            amp_val    <= span;
            present    <= ({1'b0, span} >= (DATA_W+1)'(2 * HYST));
         end else begin
            win_cnt <= win_cnt + CNT_W'(1);
            run_max <= mx;
            run_min <= mn;
         end
      end
   end

   // Hysteresis band clamps to the ADC code range at both ends.
   always_comb begin
      hi_sum = {1'b0, cur_thresh} + (DATA_W+1)'(HYST);
      hi_th  = hi_sum[DATA_W] ? ALL_1 : hi_sum[DATA_W-1:0];
      lo_th  = ({1'b0, cur_thresh} < (DATA_W+1)'(HYST)) ? '0 : cur_thresh - DATA_W'(HYST);
      above  = (adc_q > hi_th);
      below  = (adc_q < lo_th);
   end

   assign q_inc = q_cnt + Q_W'(1);

   always_ff @(posedge clk_10m) begin
      if (rst) begin
         state  <= S_LOW;
         q_cnt  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         state  <= state_nx;
         q_cnt  <= q_cnt_nx;
         rise_q <= rise_nx;
         fall_q <= fall_nx;
      end
   end

   always_comb begin
      state_nx = state;
      q_cnt_nx = q_cnt;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      case (state)
         S_LOW: begin
            if (above) begin
               if (GLITCH == 1) begin
                  state_nx = S_HIGH;
                  rise_nx  = 1'b1;
               end else begin
                  state_nx = S_RISE_CHK;
                  q_cnt_nx = Q_W'(1);
               end
            end
         end
         S_RISE_CHK: begin
            if (above) begin
               if (q_inc >= Q_W'(GLITCH)) begin
                  state_nx = S_HIGH;
                  q_cnt_nx = '0;
                  rise_nx  = 1'b1;
               end else begin
                  q_cnt_nx = q_inc;
               end
            end else begin
               state_nx = S_LOW;
               q_cnt_nx = '0;
            end
         end
         S_HIGH: begin
            if (below) begin
               if (GLITCH == 1) begin
                  state_nx = S_LOW;
                  fall_nx  = 1'b1;
               end else begin
                  state_nx = S_FALL_CHK;
                  q_cnt_nx = Q_W'(1);
               end
            end
         end
         S_FALL_CHK: begin
            if (below) begin
               if (q_inc >= Q_W'(GLITCH)) begin
                  state_nx = S_LOW;
                  q_cnt_nx = '0;
                  fall_nx  = 1'b1;
               end else begin
                  q_cnt_nx = q_inc;
               end
            end else begin
               state_nx = S_HIGH;
               q_cnt_nx = '0;
            end
         end
         default: begin
            state_nx = S_LOW;
            q_cnt_nx = '0;
         end
      endcase
      // Without a usable signal the slicer is parked low and emits nothing.
      if (!present) begin
         state_nx = S_LOW;
         q_cnt_nx = '0;
         rise_nx  = 1'b0;
         fall_nx  = 1'b0;
      end
   end

   assign bus.sq_out      = (state == S_HIGH) || (state == S_FALL_CHK);
   assign bus.rise_pulse  = rise_q;
   assign bus.fall_pulse  = fall_q;
   assign bus.thresh      = cur_thresh;
   assign bus.amp         = amp_val;
   assign bus.sig_present = present;
   assign bus.win_done    = win_pulse;
endmodule

// File: doc/adc_edge_conditioner.md
Name: adc_edge_conditioner

Overview:
Sits between the 10-bit ADC input and the frequency and duty-cycle meters. It turns raw ADC samples into a clean, glitch-free square wave, with one-cycle rising and falling edge pulses for those meters. The slicing threshold adapts to the signal: it is recomputed each window from the running min/max, and a hysteresis band plus a consecutive-sample qualifier reject noise. It also reports signal amplitude, the current threshold, and a signal-present flag for display.

Parameters:
DATA_W, 10, ADC sample width
HYST, 16, half-width of hysteresis band in LSBs
GLITCH, 2, consecutive qualifying samples required to change state (>=1)
WIN_CYCLES, 1000000, min/max tracking window length in clk_10m cycles (100 ms)

Ports:
clk_10m  in  1  10 MHz system/sample clock
rst  in  1  synchronous, active-high reset
adc_data  in  DATA_W  raw ADC sample, valid every cycle
sq_out  out  1  conditioned square wave
rise_pulse  out  1  one-cycle pulse on each qualified low->high transition
fall_pulse  out  1  one-cycle pulse on each qualified high->low transition
thresh  out  DATA_W  current slicing threshold
amp  out  DATA_W  peak-to-peak amplitude of last completed window
sig_present  out  1  amp >= 2*HYST in last completed window
win_done  out  1  one-cycle pulse when window results update

Behaviour:
- One clock domain; reset is synchronous and active-high on rst. All state updates on the rising edge of clk_10m.
- Reset values:
  - sq_out=0, rise_pulse=0, fall_pulse=0, win_done=0.
  - thresh=2^(DATA_W-1) (512), amp=0, sig_present=0.
  - FSM=LOW, window counter=0, run_max=0, run_min=all ones.
- Reset mid-operation clears everything on the next edge. No pulse is emitted on reset.
- Input stage: adc_q <= adc_data every cycle. All logic below uses adc_q.
- Window tracking:
  - Counter runs 0..WIN_CYCLES-1, then wraps.
  - Each cycle: run_max=max(run_max,adc_q), run_min=min(run_min,adc_q).
  - On the cycle the counter equals WIN_CYCLES-1, compute mx=max(run_max,adc_q) and mn=min(run_min,adc_q), then on that edge:
    - thresh <= (mx+mn)>>1, computed with a DATA_W+1-bit sum (no overflow).
    - amp <= mx-mn.
    - sig_present <= (mx-mn) >= 2*HYST.
    - win_done <= 1 for one cycle.
    - run_max <= 0, run_min <= all ones.
  - The first window completes WIN_CYCLES cycles after reset release.
- Hysteresis limits, combinational from the registered thresh:
  - hi_th = thresh+HYST, saturated at 2^DATA_W-1.
  - lo_th = thresh-HYST, saturated at 0.
  - "Above" means adc_q > hi_th; "below" means adc_q < lo_th.
- FSM states: LOW, RISE_CHK, HIGH, FALL_CHK. Qualifier counter q_cnt is ceil(log2(GLITCH+1)) bits.
  - LOW: if above, go to RISE_CHK with q_cnt=1. If GLITCH==1, go directly to HIGH instead.
  - RISE_CHK: if above, q_cnt++; when q_cnt reaches GLITCH, go to HIGH with sq_out<=1 and rise_pulse<=1 (same edge). If not above, return to LOW with q_cnt=0.
  - HIGH: mirror of LOW using "below", entering FALL_CHK.
  - FALL_CHK: mirror of RISE_CHK; on qualification go to LOW with sq_out<=0 and fall_pulse<=1.
  - sq_out=1 in HIGH and FALL_CHK, 0 otherwise.
- Latency: if a sample is first above hi_th when registered into adc_q at edge e0, and the following GLITCH-1 samples also qualify, sq_out and rise_pulse assert after edge e0+GLITCH. Falling transitions are symmetric.
- sig_present=0 overrides the FSM: it is forced to LOW with q_cnt=0 and sq_out=0. No fall_pulse is generated by the forced exit.
- A threshold update during RISE_CHK/FALL_CHK takes effect on the next comparison. q_cnt is not reset.
- A window update coinciding with a qualifying crossing: that crossing uses the old thresh.
- rise_pulse and fall_pulse are never both high in the same cycle.

Test Plan:
- Reset, then hold adc_data=512 (bench WIN_CYCLES=100): all outputs at reset values. win_done pulses at cycle 100 with amp=0, thresh=512, sig_present=0. sq_out stays 0.
- Square wave 100/900, period 50 cycles, 50% duty: after the first window thresh=500, amp=800, sig_present=1. rise_pulse every 50 cycles, sq_out high 25 cycles. Rising-edge latency from the first registered sample of 900 is exactly GLITCH edges (2).
- Same square wave with a single-cycle 900 spike inserted during the low phase: no rise_pulse and sq_out unchanged. A 2-cycle spike produces rise_pulse.
- Signal 495/505 (amp 10 < 32): sig_present=0 after the window and sq_out stays 0. Then switch to a large signal while sq_out=1 and drop amplitude: the next window forces sq_out=0 with no fall_pulse.
- Signal 1000/1023: thresh=1011, hi_th saturates at 1023. No rise is ever qualified (adc_q > 1023 is impossible). amp=23 gives sig_present=0. Also check a 0/40 signal: lo_th saturates at 0.
- Assert rst for one cycle while in RISE_CHK mid-stream: the next cycle shows FSM=LOW, thresh=512, amp=0, and no pulses. The window counter restarts, with win_done 100 cycles later.
